// File: rtl/arith_pkg.sv
// Shared arithmetic-library definitions: FSM state encoding for the
// multi-cycle units and elaboration-time helpers for digit sizing.
package arith_pkg;

    // Control states of the digit-serial arithmetic units
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Width of a counter that must hold the values 0 .. n-1 (at least 1 bit)
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // True when a digit of d bits tiles a w-bit word exactly
    function automatic bit digit_fits(input int w, input int d);
        return (d > 0) && (w >= d) && ((w % d) == 0);
    endfunction

endpackage

// File: rtl/serial_sub_if.sv
// Start/busy/done handshake plus operand and result bus of serial_sub.
interface serial_sub_if #(
    parameter int WIDTH = 8
) ();
    logic             start_in;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             borrow_in;
    logic             signed_in;
    logic             busy_out;
    logic             done_out;
    logic [WIDTH-1:0] diff_out;
    logic             borrow_out;
    logic             overflow_out;

    // The subtractor itself
    modport slave (
        input  start_in, a_in, b_in, borrow_in, signed_in,
        output busy_out, done_out, diff_out, borrow_out, overflow_out
    );

    // Whoever issues requests and consumes results
    modport master (
        output start_in, a_in, b_in, borrow_in, signed_in,
        input  busy_out, done_out, diff_out, borrow_out, overflow_out
    );
endinterface

// File: rtl/full_sub.sv
// One-bit full subtractor: diff = a - b - bin, bout set when the result
// needs a borrow from the next bit.
module full_sub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);
    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~a & bin) | (b & bin);
endmodule

// File: rtl/serial_sub_chain.sv
// Combinational DIGIT_W-bit borrow chain built from full_sub cells; it
// subtracts one digit of the operands per use.
module serial_sub_chain #(
    parameter int DIGIT_W = 1
) (
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               bin,
    output logic [DIGIT_W-1:0] diff,
    output logic               bout
);
    // Each cell keeps its own borrow nets; the chain links to the previous
    // cell by name so no single vector feeds back into itself.
    for (genvar gi = 0; gi < DIGIT_W; gi++) begin : g_cell
        logic cin;
        logic cout;
        if (gi == 0) begin : g_first
            assign cin = bin;
        end else begin : g_next
            assign cin = g_cell[gi-1].cout;
        end
        full_sub u_cell (
            .a    (a[gi]),
            .b    (b[gi]),
            .bin  (cin),
            .diff (diff[gi]),
            .bout (cout)
        );
    end

    assign bout = g_cell[DIGIT_W-1].cout;
endmodule

// File: rtl/serial_sub.sv
// Digit-serial subtractor: A - B - borrow_in over WIDTH bits, DIGIT_W bits
// per clock, least significant digit first, with a start/busy/done handshake.
module serial_sub
    import arith_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DIGIT_W = 1
) (
    input  logic         clk_in,
    input  logic         rst_n_in,
    serial_sub_if.slave  bus
);
    localparam int N  = WIDTH / DIGIT_W;
    localparam int CW = cnt_width(N);

    // Reject digit sizes that do not tile the word, and degenerate widths
    if (!digit_fits(WIDTH, DIGIT_W) || (WIDTH < 2)) begin : g_bad_params
        $error("serial_sub: DIGIT_W must divide WIDTH and WIDTH must be >= 2");
    end

    state_t           state_reg;
    state_t           state_next;
    logic             accept;
    logic             step;
    logic             last;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] diff_reg;
    logic [WIDTH-1:0] diff_shifted;
    logic [CW-1:0]    cnt_reg;
    logic             borrow_reg;
    logic             signed_reg;
    logic             a_msb_reg;
    logic             b_msb_reg;
    logic             borrow_out_reg;
    logic             overflow_reg;

    logic [DIGIT_W-1:0] digit_diff;
    logic               digit_borrow;

    // Current digit sits in the low bits of the shifting operand registers
    serial_sub_chain #(.DIGIT_W(DIGIT_W)) u_chain (
        .a    (a_reg[DIGIT_W-1:0]),
        .b    (b_reg[DIGIT_W-1:0]),
        .bin  (borrow_reg),
        .diff (digit_diff),
        .bout (digit_borrow)
    );

    // New result digits enter at the top so the LSB digit ends at bit 0
    if (N == 1) begin : g_single
        assign diff_shifted = digit_diff;
    end else begin : g_multi
        assign diff_shifted = {digit_diff, diff_reg[WIDTH-1:DIGIT_W]};
    end

    // State register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and per-cycle strobes; DONE accepts a back-to-back start
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        step       = 1'b0;
        last       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.start_in) begin
                    accept     = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                step = 1'b1;
                last = (cnt_reg == CW'(N - 1));
                if (last) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.start_in) begin
                    accept     = 1'b1;
                    state_next = ST_RUN;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Operand capture, digit stepping and final flag evaluation
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            a_reg          <= '0;
            b_reg          <= '0;
            diff_reg       <= '0;
            cnt_reg        <= '0;
            borrow_reg     <= 1'b0;
            signed_reg     <= 1'b0;
            a_msb_reg      <= 1'b0;
            b_msb_reg      <= 1'b0;
            borrow_out_reg <= 1'b0;
            overflow_reg   <= 1'b0;
        end else if (accept) begin
            a_reg          <= bus.a_in;
            b_reg          <= bus.b_in;
            borrow_reg     <= bus.borrow_in;
            signed_reg     <= bus.signed_in;
            a_msb_reg      <= bus.a_in[WIDTH-1];
            b_msb_reg      <= bus.b_in[WIDTH-1];
            cnt_reg        <= '0;
            borrow_out_reg <= 1'b0;
            overflow_reg   <= 1'b0;
        end else if (step) begin
            a_reg      <= a_reg >> DIGIT_W;
            b_reg      <= b_reg >> DIGIT_W;
            diff_reg   <= diff_shifted;
            borrow_reg <= digit_borrow;
            cnt_reg    <= cnt_reg + CW'(1);
            if (last) begin
                // Top digit just computed: its MSB is the result sign bit
                borrow_out_reg <= digit_borrow;
                overflow_reg   <= signed_reg & (a_msb_reg ^ b_msb_reg)
                                  & (digit_diff[DIGIT_W-1] ^ a_msb_reg);
            end
        end
    end

    assign bus.busy_out     = (state_reg == ST_RUN);
    assign bus.done_out     = (state_reg == ST_DONE);
    assign bus.diff_out     = diff_reg;
    assign bus.borrow_out   = borrow_out_reg;
    assign bus.overflow_out = overflow_reg;

endmodule

// File: tb/tb_serial_sub.sv
// Directed checks of serial_sub at three sizes: 8-bit/1-bit digits,
// 8-bit/4-bit digits and a 4-bit/2-bit-digit exhaustive sweep.
module tb_serial_sub;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_sub_if #(.WIDTH(8)) bus8  ();
    serial_sub_if #(.WIDTH(8)) bus84 ();
    serial_sub_if #(.WIDTH(4)) bus4  ();

    serial_sub #(.WIDTH(8), .DIGIT_W(1)) u_dut8  (.clk_in(clk), .rst_n_in(rst_n), .bus(bus8.slave));
    serial_sub #(.WIDTH(8), .DIGIT_W(4)) u_dut84 (.clk_in(clk), .rst_n_in(rst_n), .bus(bus84.slave));
    serial_sub #(.WIDTH(4), .DIGIT_W(2)) u_dut4  (.clk_in(clk), .rst_n_in(rst_n), .bus(bus4.slave));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int sel, input logic st, input logic [7:0] a, input logic [7:0] b,
                         input logic bin, input logic sgn);
        case (sel)
            0: begin
                bus8.start_in = st; bus8.a_in = a; bus8.b_in = b;
                bus8.borrow_in = bin; bus8.signed_in = sgn;
            end
            1: begin
                bus84.start_in = st; bus84.a_in = a; bus84.b_in = b;
                bus84.borrow_in = bin; bus84.signed_in = sgn;
            end
            default: begin
                bus4.start_in = st; bus4.a_in = a[3:0]; bus4.b_in = b[3:0];
                bus4.borrow_in = bin; bus4.signed_in = sgn;
            end
        endcase
    endtask

    function automatic logic done_of(input int sel);
        case (sel)
            0:       return bus8.done_out;
            1:       return bus84.done_out;
            default: return bus4.done_out;
        endcase
    endfunction

    function automatic logic busy_of(input int sel);
        case (sel)
            0:       return bus8.busy_out;
            1:       return bus84.busy_out;
            default: return bus4.busy_out;
        endcase
    endfunction

    task automatic read_res(input int sel, output logic [7:0] d, output logic bo, output logic ov);
        case (sel)
            0:       begin d = bus8.diff_out;  bo = bus8.borrow_out;  ov = bus8.overflow_out;  end
            1:       begin d = bus84.diff_out; bo = bus84.borrow_out; ov = bus84.overflow_out; end
            default: begin d = {4'h0, bus4.diff_out}; bo = bus4.borrow_out; ov = bus4.overflow_out; end
        endcase
    endtask

    // One transaction: start pulse, then count rising edges until done.
    // immediate=1 raises start at the current negedge (used from DONE).
    // noise_at>0 pulses start with junk operands at that edge count.
    task automatic run_op(input int sel, input logic [7:0] a, input logic [7:0] b,
                          input logic bin, input logic sgn, input int noise_at, input bit immediate,
                          output logic [7:0] d, output logic bo, output logic ov, output int lat);
        if (!immediate) @(negedge clk);
        drive(sel, 1'b1, a, b, bin, sgn);
        @(negedge clk);
        drive(sel, 1'b0, a, b, bin, sgn);
        check_val($sformatf("busy_after_start_s%0d", sel), 32'(busy_of(sel)), 32'd1);
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (done_of(sel)) break;
            if (noise_at > 0 && lat == noise_at)     drive(sel, 1'b1, 8'hFF, 8'h00, 1'b1, 1'b1);
            if (noise_at > 0 && lat == noise_at + 1) drive(sel, 1'b0, 8'h00, 8'hFF, 1'b0, 1'b0);
        end
        read_res(sel, d, bo, ov);
        $display("op s%0d a=%02h b=%02h bin=%0d sgn=%0d -> diff=%02h borrow=%0d ovf=%0d lat=%0d",
                 sel, a, b, bin, sgn, d, bo, ov, lat);
    endtask

    // Runs one op and compares all four results against hand-computed values
    task automatic op_check(input string tag, input int sel, input logic [7:0] a, input logic [7:0] b,
                            input logic bin, input logic sgn, input int noise_at,
                            input logic [7:0] ed, input logic eb, input logic eo, input int elat);
        logic [7:0] d;
        logic       bo, ov;
        int         lat;
        run_op(sel, a, b, bin, sgn, noise_at, 1'b0, d, bo, ov, lat);
        check_val({tag, "_diff"},   32'(d),   32'(ed));
        check_val({tag, "_borrow"}, 32'(bo),  32'(eb));
        check_val({tag, "_ovf"},    32'(ov),  32'(eo));
        check_val({tag, "_lat"},    32'(lat), 32'(elat));
    endtask

    initial begin
        logic [7:0] d;
        logic       bo, ov, saw_done;
        int         lat;
        logic [3:0] ea, eb4, ed4;
        int         full;

        drive(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        drive(1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        drive(2, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        repeat (2) @(negedge clk);

        // Reset state
        check_val("rst_busy",   32'(bus8.busy_out),     32'd0);
        check_val("rst_done",   32'(bus8.done_out),     32'd0);
        check_val("rst_diff",   32'(bus8.diff_out),     32'd0);
        check_val("rst_borrow", 32'(bus8.borrow_out),   32'd0);
        check_val("rst_ovf",    32'(bus8.overflow_out), 32'd0);
        rst_n = 1'b1;

        // Basic cases on the bit-serial unit
        op_check("t1_05m03", 0, 8'h05, 8'h03, 1'b0, 1'b0, 0, 8'h02, 1'b0, 1'b0, 8);
        // done is a single-cycle pulse and the result is held afterwards
        @(negedge clk);
        check_val("t1_done_pulse", 32'(bus8.done_out), 32'd0);
        check_val("t1_diff_held",  32'(bus8.diff_out), 32'h02);
        op_check("t2_00m01",  0, 8'h00, 8'h01, 1'b0, 1'b0, 0, 8'hFF, 1'b1, 1'b0, 8);
        op_check("t3_sgn",    0, 8'h80, 8'h01, 1'b0, 1'b1, 0, 8'h7F, 1'b0, 1'b1, 8);
        op_check("t3_unsgn",  0, 8'h80, 8'h01, 1'b0, 1'b0, 0, 8'h7F, 1'b0, 1'b0, 8);

        // Start and operand changes while busy are ignored
        op_check("t4_noise",  0, 8'h10, 8'h0F, 1'b1, 1'b0, 3, 8'h00, 1'b0, 1'b0, 8);
        // Back-to-back start issued in the DONE cycle
        run_op(0, 8'h33, 8'h11, 1'b0, 1'b0, 0, 1'b1, d, bo, ov, lat);
        check_val("t4_b2b_diff",   32'(d),   32'h22);
        check_val("t4_b2b_borrow", 32'(bo),  32'd0);
        check_val("t4_b2b_lat",    32'(lat), 32'd8);

        // Reset in the middle of an operation aborts it
        @(negedge clk);
        drive(0, 1'b1, 8'hAA, 8'h55, 1'b0, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 8'hAA, 8'h55, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        check_val("t5_busy_before", 32'(bus8.busy_out), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_val("t5_busy",   32'(bus8.busy_out),     32'd0);
        check_val("t5_done",   32'(bus8.done_out),     32'd0);
        check_val("t5_diff",   32'(bus8.diff_out),     32'd0);
        check_val("t5_borrow", 32'(bus8.borrow_out),   32'd0);
        check_val("t5_ovf",    32'(bus8.overflow_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus8.done_out) saw_done = 1'b1;
        end
        check_val("t5_no_done", 32'(saw_done), 32'd0);
        op_check("t5_after", 0, 8'h05, 8'h03, 1'b0, 1'b0, 0, 8'h02, 1'b0, 1'b0, 8);

        // Four-bit digits
        op_check("t6_a5m5a", 1, 8'hA5, 8'h5A, 1'b0, 1'b0, 0, 8'h4B, 1'b0, 1'b0, 2);

        // Exhaustive 4-bit sweep against a - b - bin
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    ea   = 4'(ia);
                    eb4  = 4'(ib);
                    full = ia - ib - ic;
                    ed4  = 4'(full);
                    run_op(2, {4'h0, ea}, {4'h0, eb4}, 1'(ic), 1'b1, 0, 1'b0, d, bo, ov, lat);
                    check_val($sformatf("sw_%0d_%0d_%0d_diff", ia, ib, ic), 32'(d), 32'(ed4));
                    check_val($sformatf("sw_%0d_%0d_%0d_borrow", ia, ib, ic), 32'(bo),
                              32'(full < 0));
                    check_val($sformatf("sw_%0d_%0d_%0d_ovf", ia, ib, ic), 32'(ov),
                              32'((ea[3] != eb4[3]) && (ed4[3] != ea[3])));
                    check_val($sformatf("sw_%0d_%0d_%0d_lat", ia, ib, ic), 32'(lat), 32'd2);
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
